// File: rtl/cla_seq_pkg.sv
// Shared types for the sequential wide CLA adder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cla_seq_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width; never below one bit so the counter always exists
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/CLA_adder.sv
// N-bit carry-look-ahead adder slice, purely combinational.
// Latency: zero cycles (combinational).
// Backpressure: none; the caller sequences it.
module CLA_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic [N-1:0] S,
  output logic         Co
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         prod;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is a flat sum of generate terms gated by the propagate run
  // above them, so no carry depends on a lower carry signal.
  always_comb begin
    c    = '0;
    prod = 1'b1;
    c[0] = Ci;
    for (int i = 1; i <= N; i++) begin
      prod = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i] = c[i] | (prod & Ci);
    end
  end

  assign S  = p ^ c[N-1:0];
  assign Co = c[N];

endmodule

// File: rtl/cla_seq_wide_adder.sv
// Wide adder that runs one N-bit CLA slice over WORDS slices, LSB slice first.
// Latency: accept at edge t -> out_valid after edge t+WORDS; one op per WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module cla_seq_wide_adder
  import cla_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  input  logic                 Ci,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   S,
  output logic                 Co,
  output logic                 V,
  output logic                 busy
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [W-1:0]     s_q;
  logic             v_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [N-1:0]     slice_a;
  logic [N-1:0]     slice_b;
  logic [N-1:0]     slice_s;
  logic             slice_co;

  // Slice operands come only from the latched registers, never from A/B
  assign slice_a = a_q[int'(idx_q)*N +: N];
  assign slice_b = b_q[int'(idx_q)*N +: N];

  CLA_adder #(.N(N)) u_slice (
    .A  (slice_a),
    .B  (slice_b),
    .Ci (carry_q),
    .S  (slice_s),
    .Co (slice_co)
  );

  // Controller: latch operands, step one slice per cycle, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      s_q         <= '0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            carry_q    <= Ci;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          s_q[int'(idx_q)*N +: N] <= slice_s;
          carry_q                 <= slice_co;
          if (idx_q == LAST_IDX) begin
            // Top sum bit is the one being produced this cycle
            v_q         <= (a_q[W-1] ~^ b_q[W-1]) & (slice_s[N-1] ^ a_q[W-1]);
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign S         = s_q;
  assign Co        = carry_q;
  assign V         = v_q;

endmodule
